tick_dispatcher: RTL and testbench

Collects single-cycle tick pulses from a bank of timer channels and hands them one at a time to a downstream consumer, such as game-logic update FSMs, over a valid/ready handshake. Each channel has a saturating pending-tick counter, so no ticks are lost while the consumer is busy. Channels are served in round-robin order. Overruns are flagged per channel with sticky bits.

---
 rtl/tick_dispatcher.sv | 148 ++++++++++++++
 tb/tb_tick_dispatcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_dispatcher.sv
// tick_dispatcher
//   Collects single-cycle tick pulses from a bank of timer channels and
//   offers them one at a time to a consumer over a valid/ready handshake.
//   Each channel keeps a saturating pending-tick counter, so ticks are not
//   lost while the consumer stalls. Channels are served round-robin, and
//   a tick that arrives at a full counter sets a sticky per-channel
//   overflow flag.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   pulse_in   in   [N_CH-1:0] one-cycle tick pulses, one bit per channel
//   evt_valid  out  an event is being offered (registered)
//   evt_id     out  [ID_W-1:0] channel index of the offered event (registered)
//   evt_ready  in   consumer accepts the offered event
//   ovf        out  [N_CH-1:0] sticky overflow flags (registered)
//   ovf_clr    in   single-cycle clear of all overflow flags
//   busy       out  any pending tick or an offer outstanding (combinational
//                   from registers only)
module tick_dispatcher #(
    parameter  int N_CH  = 6,
    parameter  int CNT_W = 3,
    localparam int ID_W  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pulse_in,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   evt_id_q, evt_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [N_CH-1:0]   cnt_nz;
    logic              accept;

    // First channel with pending ticks, searching from last+1 and wrapping
    // through last itself. Only meaningful when nz is nonzero.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] last,
                                                input logic [N_CH-1:0] nz);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last) + k) % N_CH;
            if (!found && nz[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_nz[i] = (cnt_q[i] != '0);
        end
    end

    // evt_valid is a direct decode of the state register.
    assign accept    = (state_q == S_OFFER) && evt_ready;
    assign evt_valid = (state_q == S_OFFER);
    assign evt_id    = evt_id_q;
    assign ovf       = ovf_q;
    assign busy      = (|cnt_nz) | evt_valid;

    // Pending counters and overflow flags. A pulse coinciding with an
    // accept on the same channel cancels out, so the counter cannot
    // overflow in that case. An overflow set beats a same-edge clear.
    always_comb begin
        ovf_d = ovf_clr ? '0 : ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            logic acc_i;
            acc_i    = accept && (evt_id_q == ID_W'(i));
            cnt_d[i] = cnt_q[i];
            if (pulse_in[i] && !acc_i) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (acc_i && !pulse_in[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Offer FSM. Arbitration looks at registered counts only, so a pulse
    // landing on the same edge is seen one cycle later.
    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            S_IDLE: begin
                if (|cnt_nz) begin
                    evt_id_d     = rr_pick(last_grant_q, cnt_nz);
                    last_grant_d = evt_id_d;
                    state_d      = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_CH - 1);
            ovf_q        <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tick_dispatcher.sv
// Directed testbench for tick_dispatcher (N_CH=6, CNT_W=3).
module tb_tick_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] pulse_in;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic       evt_ready;
    logic [5:0] ovf;
    logic       ovf_clr;
    logic       busy;

    int nerr = 0;
    int nchk = 0;

    int got_id[$];
    int got_cyc[$];

    tick_dispatcher #(.N_CH(6), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pulse_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // With evt_ready held high, record every accepted event until the block
    // goes idle. Bounded by max_cyc.
    task automatic collect(input int max_cyc);
        int c;
        got_id.delete();
        got_cyc.delete();
        evt_ready = 1'b1;
        c = 0;
        while (busy && c < max_cyc) begin
            if (evt_valid) begin
                got_id.push_back(int'(evt_id));
                got_cyc.push_back(c);
            end
            tick();
            c++;
        end
        check("collect_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int exp_rr[6];

        // ---------------- reset state ----------------
        do_reset();
        check("rst_valid", {31'd0, evt_valid}, 0);
        check("rst_id", {29'd0, evt_id}, 0);
        check("rst_ovf", {26'd0, ovf}, 0);
        check("rst_busy", {31'd0, busy}, 0);

        // ---------------- single pulse ----------------
        pulse_in = 6'b000100; evt_ready = 1'b1;
        tick();
        pulse_in = '0;
        check("sp_c1_valid", {31'd0, evt_valid}, 0);
        check("sp_c1_busy", {31'd0, busy}, 1);
        tick();
        check("sp_c2_valid", {31'd0, evt_valid}, 1);
        check("sp_c2_id", {29'd0, evt_id}, 2);
        tick();
        check("sp_c3_valid", {31'd0, evt_valid}, 0);
        check("sp_c3_busy", {31'd0, busy}, 0);

        // ---------------- round robin from reset ----------------
        do_reset();
        pulse_in = 6'b111111;
        tick();
        pulse_in = '0;
        collect(40);
        check("rr1_count", got_id.size(), 6);
        for (int k = 0; k < 6 && k < got_id.size(); k++) begin
            check($sformatf("rr1_id%0d", k), got_id[k], k);
            if (k > 0) check($sformatf("rr1_gap%0d", k), got_cyc[k] - got_cyc[k-1], 2);
        end

        // serve channel 2 first, then burst all channels
        pulse_in = 6'b000100;
        tick();
        pulse_in = '0;
        collect(20);
        check("rr2_pre_count", got_id.size(), 1);
        if (got_id.size() > 0) check("rr2_pre_id", got_id[0], 2);
        pulse_in = 6'b111111;
        tick();
        pulse_in = '0;
        collect(40);
        exp_rr = '{3, 4, 5, 0, 1, 2};
        check("rr2_count", got_id.size(), 6);
        for (int k = 0; k < 6 && k < got_id.size(); k++) begin
            check($sformatf("rr2_id%0d", k), got_id[k], exp_rr[k]);
        end

        // ---------------- backpressure ----------------
        do_reset();
        pulse_in = 6'b000010;
        tick();
        pulse_in = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_valid%0d", c), {31'd0, evt_valid}, 1);
            check($sformatf("bp_id%0d", c), {29'd0, evt_id}, 1);
            pulse_in = (c == 1 || c == 4 || c == 7) ? 6'b000010 : 6'b000000;
            tick();
        end
        pulse_in = '0;
        check("bp_cnt1", {29'd0, dut.cnt_q[1]}, 4);
        collect(40);
        check("bp_count", got_id.size(), 4);
        foreach (got_id[k]) check($sformatf("bp_acc_id%0d", k), got_id[k], 1);

        // ---------------- saturation / overflow ----------------
        do_reset();
        for (int p = 1; p <= 9; p++) begin
            pulse_in = 6'b000001;
            tick();
            if (p == 7) begin
                check("sat_p7_cnt", {29'd0, dut.cnt_q[0]}, 7);
                check("sat_p7_ovf", {26'd0, ovf}, 0);
            end
            if (p == 8) begin
                check("sat_p8_cnt", {29'd0, dut.cnt_q[0]}, 7);
                check("sat_p8_ovf", {26'd0, ovf}, 1);
            end
        end
        pulse_in = '0;
        check("sat_p9_cnt", {29'd0, dut.cnt_q[0]}, 7);
        collect(40);
        check("sat_count", got_id.size(), 7);
        foreach (got_id[k]) check($sformatf("sat_id%0d", k), got_id[k], 0);
        check("sat_ovf_sticky", {26'd0, ovf}, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("sat_ovf_clr", {26'd0, ovf}, 0);

        // ---------------- simultaneous events ----------------
        do_reset();
        pulse_in = 6'b001000;
        tick();
        tick();
        pulse_in = '0;
        check("sim_offer_valid", {31'd0, evt_valid}, 1);
        check("sim_offer_id", {29'd0, evt_id}, 3);
        check("sim_cnt_before", {29'd0, dut.cnt_q[3]}, 2);
        evt_ready = 1'b1; pulse_in = 6'b001000;
        tick();
        evt_ready = 1'b0; pulse_in = '0;
        check("sim_cnt_after", {29'd0, dut.cnt_q[3]}, 2);
        check("sim_valid_bubble", {31'd0, evt_valid}, 0);
        for (int p = 0; p < 5; p++) begin
            pulse_in = 6'b001000;
            tick();
        end
        check("sim_cnt_full", {29'd0, dut.cnt_q[3]}, 7);
        check("sim_ovf_pre", {26'd0, ovf}, 0);
        pulse_in = 6'b001000; ovf_clr = 1'b1;
        tick();
        pulse_in = '0; ovf_clr = 1'b0;
        check("sim_ovf_set_wins", {26'd0, ovf}, 6'b001000);

        // ---------------- reset mid-offer ----------------
        do_reset();
        for (int p = 0; p < 5; p++) begin
            pulse_in = 6'b100000;
            tick();
        end
        pulse_in = '0;
        check("ro_offer_valid", {31'd0, evt_valid}, 1);
        check("ro_offer_id", {29'd0, evt_id}, 5);
        check("ro_cnt5", {29'd0, dut.cnt_q[5]}, 5);
        rst = 1'b1; pulse_in = 6'b100000; ovf_clr = 1'b0; evt_ready = 1'b1;
        tick();
        rst = 1'b0; pulse_in = '0;
        check("ro_valid", {31'd0, evt_valid}, 0);
        check("ro_id", {29'd0, evt_id}, 0);
        check("ro_ovf", {26'd0, ovf}, 0);
        check("ro_busy", {31'd0, busy}, 0);
        check("ro_cnt5_clr", {29'd0, dut.cnt_q[5]}, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("ro_quiet%0d", c), {31'd0, evt_valid}, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
